// File: rtl/diad_trace_pkg.sv
`default_nettype none
// ============================================================================
// Module      : diad_trace_pkg
// Description : Shared definitions for the diad retirement trace transmitter:
//               packet header bytes, serializer state encoding and the packet
//               length helper.
// Config      : DIAD_TRACE_TICK_EN adds the 2-byte tick field to each packet.
// Revision    : 1.0 - initial release
// ============================================================================
package diad_trace_pkg;

  localparam logic [7:0] TRACE_HDR      = 8'hA5;  // normal packet header
  localparam logic [7:0] TRACE_HDR_DROP = 8'hA7;  // a capture was lost before this one
  localparam int         TRACE_TICK_W   = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_TICK  = 3'd2,
    ST_PC    = 3'd3,
    ST_INSTR = 3'd4
  } trace_state_e;

  // Total bytes in one packet, header included.
  function automatic int trace_pkt_bytes(input int pc_w, input int instr_w);
`ifdef DIAD_TRACE_TICK_EN
    return 1 + TRACE_TICK_W / 8 + pc_w / 8 + instr_w / 8;
`else
    return 1 + pc_w / 8 + instr_w / 8;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/diad_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : diad_trace_fifo
// Description : Synchronous first-word-fall-through FIFO holding captured
//               retirement records. A push and a pop in the same cycle are
//               both honoured even when full (the slot being read is the one
//               overwritten, and data_o shows it before the edge).
// Ports       : clk_i, rst_i   - clock, async active-high reset
//               push_i, data_i - write request and record (caller gates on full)
//               pop_i          - read request (caller gates on empty)
//               data_o         - head record
//               full_o/empty_o - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module diad_trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/diad_trace_tx.sv
`default_nettype none
// ============================================================================
// Module      : diad_trace_tx
// Description : Retirement trace transmitter. Each retiring instruction
//               (optionally with a free-running tick) is queued and sent as
//               a byte packet MSB-first over a valid/ready stream:
//               header (A5, or A7 after a lost capture), tick, PC, instr.
// Config      : define DIAD_TRACE_TICK_EN to include the 16-bit tick counter
//               and the TICK field; otherwise packets carry header, PC, instr.
// Ports       : iw_clk, iw_rst               - clock, async active-high reset
//               iw_trace_en                  - capture enable
//               iw_ro_valid/pc/instr         - retirement from the RO stage
//               iw_tx_ready                  - sink accepts byte
//               ow_tx_valid/data/sop         - byte stream, sop on header
//               ow_ovf                       - sticky capture-dropped flag
// Revision    : 1.0 - initial release
// ============================================================================
module diad_trace_tx
  import diad_trace_pkg::*;
#(
  parameter int PC_W    = 24,
  parameter int INSTR_W = 24,
  parameter int DEPTH   = 4,
  parameter int TICK_W  = 16
) (
  input  logic               iw_clk,
  input  logic               iw_rst,
  input  logic               iw_trace_en,
  input  logic               iw_ro_valid,
  input  logic [PC_W-1:0]    iw_ro_pc,
  input  logic [INSTR_W-1:0] iw_ro_instr,
  input  logic               iw_tx_ready,
  output logic               ow_tx_valid,
  output logic [7:0]         ow_tx_data,
  output logic               ow_tx_sop,
  output logic               ow_ovf
);

  localparam int TK_B = TICK_W / 8;
  localparam int PC_B = PC_W / 8;
  localparam int IN_B = INSTR_W / 8;
  localparam int MAXB = (TK_B > PC_B) ? ((TK_B > IN_B) ? TK_B : IN_B)
                                      : ((PC_B > IN_B) ? PC_B : IN_B);
  localparam int BC_W = (MAXB > 1) ? $clog2(MAXB) : 1;
`ifdef DIAD_TRACE_TICK_EN
  localparam int ENT_W = TICK_W + PC_W + INSTR_W;
`else
  localparam int ENT_W = PC_W + INSTR_W;
`endif
  // Shift register holds the whole packet: header byte plus the entry.
  localparam int SH_W = 8 + ENT_W;

  trace_state_e      state_q, state_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              drop_pend_q, drop_pend_d;
  logic              ovf_q;

  logic              w_load;
  logic              w_acc;
  logic              w_push_req;
  logic              w_push_ok;
  logic              w_drop;
  logic [7:0]        w_hdr;
  logic [SH_W-1:0]   w_sh_next;
  logic [ENT_W-1:0]  w_push_data;
  logic [ENT_W-1:0]  w_fifo_dout;
  logic              w_fifo_full;
  logic              w_fifo_empty;

`ifdef DIAD_TRACE_TICK_EN
  logic [TICK_W-1:0] tick_q;

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) tick_q <= '0;
    else        tick_q <= tick_q + TICK_W'(1);
  end

  // Capture uses the tick value before this edge's increment.
  assign w_push_data = {tick_q, iw_ro_pc, iw_ro_instr};
`else
  assign w_push_data = {iw_ro_pc, iw_ro_instr};
`endif

  // A full FIFO can still take a capture when the serializer pops this cycle.
  assign w_push_req = iw_trace_en && iw_ro_valid;
  assign w_push_ok  = w_push_req && (!w_fifo_full || w_load);
  assign w_drop     = w_push_req && !w_push_ok;

  diad_trace_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (iw_clk),
    .rst_i   (iw_rst),
    .push_i  (w_push_ok),
    .pop_i   (w_load),
    .data_i  (w_push_data),
    .data_o  (w_fifo_dout),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty)
  );

  assign w_acc     = (state_q != ST_IDLE) && iw_tx_ready;
  assign w_hdr     = drop_pend_q ? TRACE_HDR_DROP : TRACE_HDR;
  // Zero fill means the byte shown after the last field is 8'h00.
  assign w_sh_next = {sh_q[SH_W-9:0], 8'h00};

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    w_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        w_load = !w_fifo_empty;
      end
      ST_HDR: begin
        if (w_acc) begin
          sh_d   = w_sh_next;
          bcnt_d = '0;
`ifdef DIAD_TRACE_TICK_EN
          state_d = ST_TICK;
`else
          state_d = ST_PC;
`endif
        end
      end
`ifdef DIAD_TRACE_TICK_EN
      ST_TICK: begin
        if (w_acc) begin
          sh_d = w_sh_next;
          if (bcnt_q == BC_W'(TK_B - 1)) begin
            bcnt_d  = '0;
            state_d = ST_PC;
          end else begin
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end
      end
`endif
      ST_PC: begin
        if (w_acc) begin
          sh_d = w_sh_next;
          if (bcnt_q == BC_W'(PC_B - 1)) begin
            bcnt_d  = '0;
            state_d = ST_INSTR;
          end else begin
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end
      end
      ST_INSTR: begin
        if (w_acc) begin
          sh_d = w_sh_next;
          if (bcnt_q == BC_W'(IN_B - 1)) begin
            bcnt_d = '0;
            // Chain straight into the next packet when one is waiting.
            if (!w_fifo_empty) w_load = 1'b1;
            else               state_d = ST_IDLE;
          end else begin
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (w_load) begin
      sh_d    = {w_hdr, w_fifo_dout};
      state_d = ST_HDR;
      bcnt_d  = '0;
    end
  end

  // The header reflects drops seen before this load; a drop on the same
  // edge belongs to the following packet, so setting wins over clearing.
  always_comb begin
    drop_pend_d = drop_pend_q;
    if (w_load) drop_pend_d = 1'b0;
    if (w_drop) drop_pend_d = 1'b1;
  end

  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q     <= ST_IDLE;
      bcnt_q      <= '0;
      sh_q        <= '0;
      drop_pend_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bcnt_q      <= bcnt_d;
      sh_q        <= sh_d;
      drop_pend_q <= drop_pend_d;
      ovf_q       <= ovf_q | w_drop;
    end
  end

  assign ow_tx_valid = (state_q != ST_IDLE);
  assign ow_tx_data  = sh_q[SH_W-1 -: 8];
  assign ow_tx_sop   = (state_q == ST_HDR);
  assign ow_ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_diad_trace_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_diad_trace_tx
// Description : Self-checking bench for diad_trace_tx. A packet-level model
//               (queue of captures, list of pending bytes) predicts the byte
//               stream; a negedge compare process checks every cycle, and
//               directed scenarios pin literal packet contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_diad_trace_tx;

  localparam int PC_W    = 24;
  localparam int INSTR_W = 24;
  localparam int DEPTH   = 4;
`ifdef DIAD_TRACE_TICK_EN
  localparam int PKT_LEN = 9;
`else
  localparam int PKT_LEN = 7;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               en = 1'b0;
  logic               valid = 1'b0;
  logic [PC_W-1:0]    pc = '0;
  logic [INSTR_W-1:0] instr = '0;
  logic               ready = 1'b0;
  logic               tx_valid;
  logic [7:0]         tx_data;
  logic               tx_sop;
  logic               ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  diad_trace_tx #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W),
    .DEPTH   (DEPTH),
    .TICK_W  (16)
  ) dut (
    .iw_clk      (clk),
    .iw_rst      (rst),
    .iw_trace_en (en),
    .iw_ro_valid (valid),
    .iw_ro_pc    (pc),
    .iw_ro_instr (instr),
    .iw_tx_ready (ready),
    .ow_tx_valid (tx_valid),
    .ow_tx_data  (tx_data),
    .ow_tx_sop   (tx_sop),
    .ow_ovf      (ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0]        mq_t[$];
  logic [PC_W-1:0]    mq_p[$];
  logic [INSTR_W-1:0] mq_i[$];
  logic [7:0]         cur[$];   // bytes of the packet in flight not yet accepted
  bit                 m_pend;
  bit                 m_ovf;
  logic [15:0]        m_tick;

  always @(posedge clk or posedge rst) begin
    int  n;
    bit  pop;
    logic [15:0]        t;
    logic [PC_W-1:0]    p;
    logic [INSTR_W-1:0] w;
    if (rst) begin
      mq_t.delete(); mq_p.delete(); mq_i.delete(); cur.delete();
      m_pend = 0; m_ovf = 0; m_tick = 16'h0;
    end else begin
      n   = mq_p.size();
      pop = (n > 0) && ((cur.size() == 0) || (cur.size() == 1 && ready));
      if (cur.size() > 0 && ready) void'(cur.pop_front());
      if (pop) begin
        t = mq_t.pop_front(); p = mq_p.pop_front(); w = mq_i.pop_front();
        cur.delete();
        cur.push_back(m_pend ? 8'hA7 : 8'hA5);
        m_pend = 0;
`ifdef DIAD_TRACE_TICK_EN
        cur.push_back(t[15:8]);
        cur.push_back(t[7:0]);
`endif
        for (int b = PC_W / 8 - 1; b >= 0; b--)    cur.push_back(p[b*8 +: 8]);
        for (int b = INSTR_W / 8 - 1; b >= 0; b--) cur.push_back(w[b*8 +: 8]);
      end
      if (en && valid) begin
        if (n < DEPTH || pop) begin
          mq_t.push_back(m_tick); mq_p.push_back(pc); mq_i.push_back(instr);
        end else begin
          m_ovf = 1; m_pend = 1;
        end
      end
      m_tick = m_tick + 16'h1;
    end
  end

  // ---------------- per-cycle compare + byte recorder ----------------
  logic [7:0] seen[$];
  logic [7:0] hdrs[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid", tx_valid, 32'(cur.size() > 0));
      chk("ovf", ovf, 32'(m_ovf));
      if (cur.size() > 0) begin
        chk("data", tx_data, cur[0]);
        chk("sop", tx_sop, 32'(cur.size() == PKT_LEN));
      end else begin
        chk("sop_idle", tx_sop, 0);
      end
      if (tx_valid && ready) begin
        seen.push_back(tx_data);
        if (tx_sop) hdrs.push_back(tx_data);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    valid = 0; en = 0; ready = 0;
    rst = 1;
    seen.delete(); hdrs.delete();
    @(posedge clk); #2 rst = 0;
  endtask

  task automatic drain(input string name);
    int i;
    ready = 1; valid = 0;
    for (i = 0; i < 2000; i++) begin
      @(posedge clk);
      if (mq_p.size() == 0 && cur.size() == 0) break;
    end
    @(negedge clk);
    chk({name, "_drained"}, 32'(i < 2000), 1);
    chk({name, "_idle"}, tx_valid, 0);
    #3;
  endtask

  task automatic retire_at_next(input logic [PC_W-1:0] p, input logic [INSTR_W-1:0] w);
    valid = 1; pc = p; instr = w;
    @(posedge clk); #2 valid = 0;
  endtask

  logic [7:0] exp_q[$];
  logic       pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
`ifdef DIAD_TRACE_TICK_EN
    exp_q = {8'hA5, 8'h00, 8'h03, 8'h00, 8'h00, 8'h10, 8'h12, 8'h34, 8'h56};
`else
    exp_q = {8'hA5, 8'h00, 8'h00, 8'h10, 8'h12, 8'h34, 8'h56};
`endif
    // Reset state
    #1;
    chk("rst_valid", tx_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_sop", tx_sop, 0);
    chk("rst_ovf", ovf, 0);

    // Single retire at tick 3
    do_reset();
    ready = 1; en = 1;
    repeat (3) @(posedge clk);
    #2 retire_at_next(24'h000010, 24'h123456);
    drain("single");
    chk("single_len", seen.size(), PKT_LEN);
    chk("single_hdrs", hdrs.size(), 1);
    for (int i = 0; i < PKT_LEN; i++) chk($sformatf("single_b%0d", i), seen[i], exp_q[i]);

    // Backpressure with ready 1,0,0,1,...
    do_reset();
    ready = 1; en = 1;
    repeat (3) @(posedge clk);
    #2 valid = 1; pc = 24'h000010; instr = 24'h123456;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2 valid = 0;
      ready = pat[c % 4];
    end
    drain("bp");
    chk("bp_len", seen.size(), PKT_LEN);
    for (int i = 0; i < PKT_LEN; i++) chk($sformatf("bp_b%0d", i), seen[i], exp_q[i]);

    // Burst / overflow: six retires while the sink stalls
    do_reset();
    en = 1;
    for (int k = 0; k < 6; k++) begin
      valid = 1; pc = 24'(k + 1); instr = 24'(32'hA00 + k);
      @(posedge clk); #2;
    end
    valid = 0;
    @(negedge clk);
    chk("burst_ovf", ovf, 1);
    drain("burst");
    chk("burst_npkt", hdrs.size(), 5);
    chk("burst_h0", hdrs[0], 8'hA5);
    chk("burst_h1", hdrs[1], 8'hA7);
    chk("burst_h2", hdrs[2], 8'hA5);
    chk("burst_h4", hdrs[4], 8'hA5);
    chk("burst_len", seen.size(), 5 * PKT_LEN);

    // Full FIFO, retire on the edge the serializer pops
    do_reset();
    en = 1;
    for (int k = 0; k < 5; k++) begin
      valid = 1; pc = 24'(k + 16); instr = 24'(k);
      @(posedge clk); #2;
    end
    valid = 0;
    @(posedge clk); #2 ready = 1;
    repeat (PKT_LEN - 1) @(posedge clk);
    #2 retire_at_next(24'hBEEF01, 24'h00C0DE);
    drain("fullpop");
    chk("fullpop_ovf", ovf, 0);
    chk("fullpop_npkt", hdrs.size(), 6);
    chk("fullpop_last_pc_lsb", seen[seen.size() - 4], 8'h01);

    // Enable gating
    do_reset();
    en = 0; ready = 1;
    for (int c = 0; c < 40; c++) begin
      valid = 1'($urandom); pc = 24'($urandom); instr = 24'($urandom);
      @(posedge clk); #2;
    end
    drain("gate");
    chk("gate_bytes", seen.size(), 0);

    // Tick wrap: capture on edge 65541 after reset release
    do_reset();
    en = 1; ready = 1;
    repeat (65540) @(posedge clk);
    #2 retire_at_next(24'h0000AB, 24'h0000CD);
    drain("wrap");
    chk("wrap_len", seen.size(), PKT_LEN);
`ifdef DIAD_TRACE_TICK_EN
    chk("wrap_tick_hi", seen[1], 8'h00);
    chk("wrap_tick_lo", seen[2], 8'h04);
`endif
    chk("wrap_instr_lsb", seen[PKT_LEN - 1], 8'hCD);

    // Randomized traffic with stall phases to provoke drops
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      en    = ($urandom % 4) != 0;
      valid = 1'($urandom);
      ready = ((c % 200) < 60) ? 1'b0 : (($urandom % 3) != 0);
      pc    = 24'($urandom);
      instr = 24'($urandom);
      @(posedge clk); #2;
    end
    en = 0;
    drain("rand");

    // Reset in the middle of a packet
    do_reset();
    en = 1; ready = 1;
    retire_at_next(24'h000077, 24'h000088);
    begin
      int w;
      for (w = 0; w < 50 && seen.size() < 4; w++) @(negedge clk);
      chk("mid_reached4", 32'(seen.size() >= 4), 1);
    end
    @(posedge clk); #3 rst = 1;
    seen.delete(); hdrs.delete();
    #1;
    chk("mid_valid_async", tx_valid, 0);
    chk("mid_sop_async", tx_sop, 0);
    @(posedge clk); #2 rst = 0;
    retire_at_next(24'h000010, 24'h123456);
    drain("mid");
    chk("mid_len", seen.size(), PKT_LEN);
    chk("mid_hdr", seen[0], 8'hA5);
`ifdef DIAD_TRACE_TICK_EN
    chk("mid_tick_lo", seen[2], 8'h00);
`endif
    chk("mid_pc_lsb", seen[PKT_LEN - 4], 8'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
